// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch front end: FSM state encoding and
// default PC/address parameters.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    BUBBLE = 2'd1,
    RUN    = 2'd2,
    HALT   = 2'd3
  } fetch_state_e;

  localparam int              XLEN     = 64;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0;
  localparam int              PC_STEP  = 4;
  localparam int              CNT_W    = 32;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch-issue control wrapped around an external
// 2:1 next-PC mux; handles stall, halt/resume, redirects and fetch counting.
module pc_fetch_ctrl #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int              PC_STEP  = fetch_pkg::PC_STEP,
  parameter int              CNT_W    = fetch_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  output logic [XLEN-1:0]  mux_a,
  output logic [XLEN-1:0]  mux_b,
  output logic             mux_sel,
  input  logic [XLEN-1:0]  mux_out,
  output logic [XLEN-1:0]  pc_out,
  output logic             pc_valid,
  input  logic             pc_ready,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_count
);
  import fetch_pkg::*;

  localparam logic [XLEN-1:0] STEP_MASK = XLEN'(PC_STEP - 1);

  fetch_state_e     state_r, state_nx_s;
  logic [XLEN-1:0]  pc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             misalign_r;
  logic             pc_valid_r;
  logic             pc_load_s;
  logic             cnt_inc_s;
  logic             misalign_set_s;
  logic             target_aligned_s;

  assign mux_a       = pc_r + XLEN'(PC_STEP);
  assign mux_b       = branch_target;
  assign mux_sel     = branch_taken;
  assign pc_out      = pc_r;
  assign pc_valid    = pc_valid_r;
  assign misalign    = misalign_r;
  assign fetch_count = cnt_r;

  assign target_aligned_s = ((branch_target & STEP_MASK) == {XLEN{1'b0}});

  // Next-state and datapath enables; redirect beats halt beats normal flow.
  always_comb begin
    state_nx_s     = state_r;
    pc_load_s      = 1'b0;
    cnt_inc_s      = 1'b0;
    misalign_set_s = 1'b0;
    if (state_r == BOOT) begin
      state_nx_s = RUN;
    end else if (branch_taken) begin
      if (target_aligned_s) begin
        pc_load_s  = 1'b1;
        state_nx_s = halt ? HALT : BUBBLE;
      end else begin
        misalign_set_s = 1'b1;
        state_nx_s     = HALT;
      end
    end else if (halt) begin
      state_nx_s = HALT;
    end else begin
      case (state_r)
        RUN: begin
          if (pc_ready && !stall) begin
            pc_load_s = 1'b1;
            cnt_inc_s = 1'b1;
          end else begin
            pc_load_s = 1'b0;
          end
          state_nx_s = RUN;
        end
        BUBBLE: state_nx_s = RUN;
        HALT: begin
          // A misaligned redirect pins the core in HALT until reset.
          if (resume && !misalign_r) begin
            state_nx_s = RUN;
          end else begin
            state_nx_s = HALT;
          end
        end
        default: state_nx_s = BOOT;
      endcase
    end
  end

  // State, PC, counter and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      cnt_r      <= {CNT_W{1'b0}};
      misalign_r <= 1'b0;
      pc_valid_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      pc_valid_r <= (state_nx_s == RUN);
      if (pc_load_s) begin
        pc_r <= mux_out;
      end
      if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (misalign_set_s) begin
        misalign_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural next-PC mux and
// hand-computed expected PC / valid / count values.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [63:0] mux_a;
  logic [63:0] mux_b;
  logic        mux_sel;
  logic [63:0] mux_out;
  logic [63:0] pc_out;
  logic        pc_valid;
  logic        pc_ready;
  logic        misalign;
  logic [31:0] fetch_count;

  int n_vec;
  int n_err;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .halt         (halt),
    .resume       (resume),
    .mux_a        (mux_a),
    .mux_b        (mux_b),
    .mux_sel      (mux_sel),
    .mux_out      (mux_out),
    .pc_out       (pc_out),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .misalign     (misalign),
    .fetch_count  (fetch_count)
  );

  // External 2:1 next-PC mux.
  assign mux_out = mux_sel ? mux_b : mux_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [63:0] pc, input logic pv,
                           input logic [31:0] cnt);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".valid"}, {63'd0, pc_valid}, {63'd0, pv});
    chk({tag, ".count"}, {32'd0, fetch_count}, {32'd0, cnt});
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    branch_taken = 1'b0;
    branch_target = 64'h0;
    stall = 1'b0;
    halt = 1'b0;
    resume = 1'b0;
    pc_ready = 1'b1;
    #3;
    chk_state("reset", 64'h0, 1'b0, 32'd0);
    chk("reset.misalign", {63'd0, misalign}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("boot.valid", {63'd0, pc_valid}, 64'd0);
    tick();
    chk_state("seq0", 64'h0, 1'b1, 32'd0);
    tick();
    chk_state("seq4", 64'h4, 1'b1, 32'd1);
    tick();
    chk_state("seq8", 64'h8, 1'b1, 32'd2);

    pc_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_state("notready", 64'h8, 1'b1, 32'd2);
    pc_ready = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk_state("stall", 64'h8, 1'b1, 32'd2);
    stall = 1'b0;
    tick();
    chk_state("seqC", 64'hC, 1'b1, 32'd3);
    tick();
    chk_state("seq10", 64'h10, 1'b1, 32'd4);

    branch_taken = 1'b1;
    branch_target = 64'h100;
    #1;
    chk("mux_sel", {63'd0, mux_sel}, 64'd1);
    chk("mux_b", mux_b, 64'h100);
    chk("mux_a", mux_a, 64'h14);
    tick();
    branch_taken = 1'b0;
    chk_state("redir", 64'h100, 1'b0, 32'd4);
    tick();
    chk_state("redir.present", 64'h100, 1'b1, 32'd4);
    tick();
    chk_state("redir.next", 64'h104, 1'b1, 32'd5);

    branch_taken = 1'b1;
    branch_target = 64'h20;
    tick();
    branch_taken = 1'b0;
    tick();
    chk_state("to20", 64'h20, 1'b1, 32'd5);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk_state("halt", 64'h20, 1'b0, 32'd5);
    for (int i = 0; i < 5; i++) tick();
    chk_state("halted", 64'h20, 1'b0, 32'd5);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk_state("resume", 64'h20, 1'b1, 32'd5);
    tick();
    chk_state("resume.next", 64'h24, 1'b1, 32'd6);

    branch_taken = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    chk("wrap.mux_a", mux_a, 64'h0);
    tick();
    chk_state("wrap.top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'd6);
    tick();
    chk_state("wrap.zero", 64'h0, 1'b1, 32'd7);

    branch_taken = 1'b1;
    branch_target = 64'h102;
    tick();
    branch_taken = 1'b0;
    chk_state("misal", 64'h0, 1'b0, 32'd7);
    chk("misal.flag", {63'd0, misalign}, 64'd1);
    resume = 1'b1;
    tick();
    tick();
    resume = 1'b0;
    chk_state("misal.resume", 64'h0, 1'b0, 32'd7);
    chk("misal.sticky", {63'd0, misalign}, 64'd1);

    reset = 1'b1;
    #2;
    chk("misal.clear", {63'd0, misalign}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk_state("rerun", 64'h8, 1'b1, 32'd2);
    #3;
    reset = 1'b1;
    #1;
    chk_state("async_reset", 64'h0, 1'b0, 32'd0);
    chk("async_reset.misalign", {63'd0, misalign}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
